somador_serial_ctrl: RTL and testbench

Bit-serial sequencer that sits directly upstream of the team's 1-bit full adder cell (somador_1bit) and drives it.
- Accepts two N-bit operands and a carry-in on a start pulse.
- Feeds the operands LSB-first into the adder cell, one bit per clock.
- Registers the adder's carry-out as the next carry-in.
- Reassembles the sum bits into an N-bit result with a final carry, for the downstream 7-segment decoder.

---
 rtl/somador_serial_ctrl.sv | 91 +++++++++
 tb/tb_somador_serial_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/somador_serial_ctrl.sv
// Bit-serial sequencer for the somador_1bit full adder cell: shifts operands out
// LSB-first, recirculates the carry and reassembles an N-bit sum plus final carry.
module somador_serial_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         te_in,
  output logic         X,
  output logic         Y,
  output logic         TE,
  input  logic         S,
  input  logic         TS,
  output logic         ocupado,
  output logic         pronto,
  output logic [N-1:0] soma,
  output logic         ts_final
);

  typedef enum logic [1:0] {OCIOSO, SOMANDO, PRONTO} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  a_reg, b_reg, res_reg, soma_reg;
  logic          carry_reg, ts_final_reg;
  logic          last_bit;

  assign last_bit = (cnt_reg == CW'(N - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:  if (inicio) state_next = SOMANDO;
      SOMANDO: if (last_bit) state_next = PRONTO;
      PRONTO:  state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= OCIOSO;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      carry_reg    <= 1'b0;
      soma_reg     <= '0;
      ts_final_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        OCIOSO: begin
          if (inicio) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= te_in;
            cnt_reg   <= '0;
          end
        end
        SOMANDO: begin
          a_reg     <= {1'b0, a_reg[N-1:1]};
          b_reg     <= {1'b0, b_reg[N-1:1]};
          res_reg   <= {S, res_reg[N-1:1]};
          carry_reg <= TS;
          // Counter stops at N-1; it is reloaded on the next accepted start.
          if (!last_bit) cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            soma_reg     <= {S, res_reg[N-1:1]};
            ts_final_reg <= TS;
          end
        end
        default: ;
      endcase
    end
  end

  // Adder-cell drive comes only from registers, gated by the registered state.
  assign ocupado  = (state_reg == SOMANDO);
  assign pronto   = (state_reg == PRONTO);
  assign X        = ocupado & a_reg[0];
  assign Y        = ocupado & b_reg[0];
  assign TE       = ocupado & carry_reg;
  assign soma     = soma_reg;
  assign ts_final = ts_final_reg;

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Directed and exhaustive bench for somador_serial_ctrl with a behavioural
// full adder closing the loop on X/Y/TE -> S/TS.
module tb_somador_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inicio = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       te_in = 1'b0;
  logic       X, Y, TE, S, TS, ocupado, pronto, ts_final;
  logic [3:0] soma;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] prev_soma = '0;

  somador_serial_ctrl #(.N(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .a(a), .b(b), .te_in(te_in),
    .X(X), .Y(Y), .TE(TE), .S(S), .TS(TS),
    .ocupado(ocupado), .pronto(pronto), .soma(soma), .ts_final(ts_final)
  );

  assign S  = X ^ Y ^ TE;
  assign TS = (X & Y) | (TE & (X ^ Y));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge in OCIOSO; returns at a negedge in OCIOSO.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tte,
                        input logic [3:0] exp_te, input logic [3:0] exp_soma,
                        input logic exp_ts, input logic poke);
    a = ta; b = tb_v; te_in = tte; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ocupado[%0d]", i), {7'd0, ocupado}, 8'd1);
      chk($sformatf("pronto_busy[%0d]", i), {7'd0, pronto}, 8'd0);
      chk($sformatf("X[%0d]", i), {7'd0, X}, {7'd0, ta[i]});
      chk($sformatf("Y[%0d]", i), {7'd0, Y}, {7'd0, tb_v[i]});
      chk($sformatf("TE[%0d]", i), {7'd0, TE}, {7'd0, exp_te[i]});
      if (i == 0) chk("soma_held", {4'd0, soma}, {4'd0, prev_soma});
      if (poke && i == 1) begin
        inicio = 1'b1; a = 4'hF; b = 4'hF; te_in = 1'b1;
      end
      if (poke && i == 2) inicio = 1'b0;
      @(negedge clk);
    end
    chk("pronto", {7'd0, pronto}, 8'd1);
    chk("ocupado_done", {7'd0, ocupado}, 8'd0);
    chk("xyte_done", {5'd0, X, Y, TE}, 8'd0);
    chk("soma", {4'd0, soma}, {4'd0, exp_soma});
    chk("ts_final", {7'd0, ts_final}, {7'd0, exp_ts});
    prev_soma = exp_soma;
    if (poke) inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    chk("idle_ocupado", {7'd0, ocupado}, 8'd0);
    chk("idle_pronto", {7'd0, pronto}, 8'd0);
  endtask

  initial begin
    logic [4:0] ref_sum;
    logic [3:0] ete;
    logic       c;
    int         hits[$];

    @(negedge clk);
    @(negedge clk);
    chk("rst_ocupado", {7'd0, ocupado}, 8'd0);
    chk("rst_pronto", {7'd0, pronto}, 8'd0);
    chk("rst_xyte", {5'd0, X, Y, TE}, 8'd0);
    chk("rst_soma", {3'd0, ts_final, soma}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 4'b1000, 1'b0, 1'b0);
    run_op(4'b1111, 4'b0001, 1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run_op(4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1);

    // Abort mid-operation with reset; soma currently holds 0010.
    a = 4'b0110; b = 4'b0011; te_in = 1'b0; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ocupado", {7'd0, ocupado}, 8'd0);
    chk("abort_soma", {4'd0, soma}, 8'd0);
    chk("abort_xyte", {5'd0, X, Y, TE}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_soma = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nopronto[%0d]", i), {7'd0, pronto}, 8'd0);
    end
    run_op(4'b0110, 4'b0011, 1'b0, 4'b1100, 4'b1001, 1'b0, 1'b0);

    // inicio held high: back-to-back operations every N+2 cycles.
    a = 4'b0101; b = 4'b0101; te_in = 1'b0; inicio = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (pronto) begin
        hits.push_back(cyc);
        chk("hold_soma", {3'd0, ts_final, soma}, 8'b0000_1010);
      end
    end
    inicio = 1'b0;
    chk("hold_count", 8'(hits.size() >= 4), 8'd1);
    for (int i = 1; i < hits.size(); i++)
      chk($sformatf("hold_period[%0d]", i), 8'(hits[i] - hits[i-1]), 8'd6);
    @(negedge clk);
    @(negedge clk);
    prev_soma = 4'b1010;

    for (int v = 0; v < 512; v++) begin
      logic [3:0] ta, tbv;
      logic       tc;
      ta = v[3:0]; tbv = v[7:4]; tc = v[8];
      ref_sum = {1'b0, ta} + {1'b0, tbv} + {4'd0, tc};
      c = tc;
      for (int i = 0; i < 4; i++) begin
        ete[i] = c;
        c = (ta[i] & tbv[i]) | (c & (ta[i] ^ tbv[i]));
      end
      run_op(ta, tbv, tc, ete, ref_sum[3:0], ref_sum[4], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
